// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between instruction fetch and load/store,
// with data priority, a fetch anti-starvation limit, store lane steering and load extraction.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int STREAK  = 4,
    parameter int MEM_AW  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              f_valid,
    input  logic [31:0]       f_addr,
    output logic              f_ready,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [2:0]        d_func3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STREAK + 1);
    localparam logic [CW-1:0] LAT_C    = CW'(MEM_LAT);
    localparam logic [SW-1:0] STREAK_C = SW'(STREAK);
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_F = 2'd1, WAIT_D = 2'd2} state_t;

    // Unlisted func3 codes fall back to a full word access.
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return SZ_B;
            3'd1, 3'd5: return SZ_H;
            default:    return SZ_W;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (access_size(f3))
            SZ_H:    return off[0];
            SZ_W:    return |off;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd4:    return {24'h000000, sh[7:0]};
            3'd5:    return {16'h0000, sh[15:0]};
            default: return word;
        endcase
    endfunction

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [SW-1:0]   streak_r;
    logic            drop_r;
    logic [2:0]      lat_f3_r;
    logic [1:0]      lat_off_r;
    logic            lat_we_r;
    logic            f_rvalid_r, d_rvalid_r, d_err_r;
    logic [31:0]     f_rdata_r, d_rdata_r;

    logic            idle_s, f_ok_s, force_f_s, d_grant_s, f_grant_s, d_mis_s, d_mem_s;
    logic            mem_req_s, mem_we_s;
    logic [3:0]      mem_wmask_s;
    logic [MEM_AW-1:0] mem_addr_s;
    logic [31:0]     mem_wdata_s;
    logic            unused_addr_bits_s;

    assign unused_addr_bits_s = ^{f_addr[31:MEM_AW+2], f_addr[1:0], d_addr[31:MEM_AW+2]};

    // Grant selection and memory strobes; everything is forced low while reset is asserted.
    always_comb begin
        idle_s    = reset && (state_r == IDLE);
        f_ok_s    = f_valid && !flush;
        force_f_s = f_ok_s && (streak_r == STREAK_C);
        d_grant_s = idle_s && d_valid && !force_f_s;
        f_grant_s = idle_s && f_ok_s && !d_grant_s;
        d_mis_s   = misaligned(d_func3, d_addr[1:0]);
        d_mem_s   = d_grant_s && !d_mis_s;
        mem_req_s = f_grant_s || d_mem_s;
        mem_we_s  = d_mem_s && d_we;
        mem_addr_s  = {MEM_AW{1'b0}};
        mem_wmask_s = 4'h0;
        mem_wdata_s = 32'h0;
        if (f_grant_s) begin
            mem_addr_s = f_addr[MEM_AW+1:2];
        end else if (d_mem_s) begin
            mem_addr_s = d_addr[MEM_AW+1:2];
        end else begin
            mem_addr_s = {MEM_AW{1'b0}};
        end
        if (mem_we_s) begin
            case (access_size(d_func3))
                SZ_B: begin
                    mem_wmask_s = 4'b0001 << d_addr[1:0];
                    mem_wdata_s = {4{d_wdata[7:0]}};
                end
                SZ_H: begin
                    mem_wmask_s = 4'b0011 << d_addr[1:0];
                    mem_wdata_s = {2{d_wdata[15:0]}};
                end
                default: begin
                    mem_wmask_s = 4'hF;
                    mem_wdata_s = d_wdata;
                end
            endcase
        end else begin
            mem_wmask_s = 4'h0;
            mem_wdata_s = 32'h0;
        end
    end

    assign f_ready   = f_grant_s;
    assign d_ready   = d_grant_s;
    assign mem_req   = mem_req_s;
    assign mem_we    = mem_we_s;
    assign mem_wmask = mem_wmask_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign f_rvalid  = f_rvalid_r;
    assign f_rdata   = f_rdata_r;
    assign d_rvalid  = d_rvalid_r;
    assign d_rdata   = d_rdata_r;
    assign d_err     = d_err_r;

    // Transaction FSM: waits out the memory latency and registers the one-cycle response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            streak_r   <= {SW{1'b0}};
            drop_r     <= 1'b0;
            lat_f3_r   <= 3'd0;
            lat_off_r  <= 2'd0;
            lat_we_r   <= 1'b0;
            f_rvalid_r <= 1'b0;
            f_rdata_r  <= 32'h0;
            d_rvalid_r <= 1'b0;
            d_rdata_r  <= 32'h0;
            d_err_r    <= 1'b0;
        end else begin
            f_rvalid_r <= 1'b0;
            f_rdata_r  <= 32'h0;
            d_rvalid_r <= 1'b0;
            d_rdata_r  <= 32'h0;
            d_err_r    <= 1'b0;
            if (d_grant_s) begin
                if (f_valid) begin
                    streak_r <= (streak_r == STREAK_C) ? streak_r : streak_r + 1'b1;
                end else begin
                    streak_r <= {SW{1'b0}};
                end
            end else if (f_grant_s) begin
                streak_r <= {SW{1'b0}};
            end else begin
                streak_r <= streak_r;
            end
            case (state_r)
                IDLE: begin
                    cnt_r  <= CW'(1);
                    drop_r <= 1'b0;
                    if (f_grant_s) begin
                        state_r <= WAIT_F;
                    end else if (d_mem_s) begin
                        state_r   <= WAIT_D;
                        lat_f3_r  <= d_func3;
                        lat_off_r <= d_addr[1:0];
                        lat_we_r  <= d_we;
                    end else if (d_grant_s) begin
                        d_rvalid_r <= 1'b1;
                        d_err_r    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_F: begin
                    if (cnt_r == LAT_C) begin
                        state_r <= IDLE;
                        if (!drop_r && !flush) begin
                            f_rvalid_r <= 1'b1;
                            f_rdata_r  <= mem_rdata;
                        end
                    end else begin
                        cnt_r  <= cnt_r + 1'b1;
                        drop_r <= drop_r || flush;
                    end
                end
                WAIT_D: begin
                    if (cnt_r == LAT_C) begin
                        state_r    <= IDLE;
                        d_rvalid_r <= 1'b1;
                        d_rdata_r  <= lat_we_r ? 32'h0 : load_extract(lat_f3_r, lat_off_r, mem_rdata);
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences, and
// randomized traffic checked against a timestamp-based transaction model.
module tb_mem_port_arbiter;
    localparam int MEM_LAT = 2;
    localparam int STREAK  = 4;
    localparam int MEM_AW  = 12;
    localparam int NR      = 1500;

    logic clk = 1'b0, reset = 1'b0, flush = 1'b0, f_valid = 1'b0, d_valid = 1'b0, d_we = 1'b0;
    logic [31:0] f_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, mem_rdata = 32'h0;
    logic [2:0]  d_func3 = 3'd0;
    logic f_ready, f_rvalid, d_ready, d_rvalid, d_err, mem_req, mem_we;
    logic [31:0] f_rdata, d_rdata, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [MEM_AW-1:0] mem_addr;

    int total = 0;
    int bad = 0;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STREAK(STREAK), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_valid(d_valid), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [1:0] off);
        int m;
        m = ((1 << nbytes(f3)) - 1) << int'(off);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (nbytes(f3) == 1) return {24'h0, w[7:0]} * 32'h01010101;
        if (nbytes(f3) == 2) return {16'h0, w[15:0]} * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        int bits;
        logic [63:0] v;
        bits = 8 * nbytes(f3);
        v = {32'h0, word} >> (8 * int'(off));
        if (bits < 32) v = v & ((64'd1 << bits) - 64'd1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v[bits-1]) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    typedef struct {
        logic [2:0]  f3;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic        err;
        logic [3:0]  wmask;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t tab[13];
    logic [31:0] rd_hist[NR];
    bit          pf[NR + 8];
    bit          pd[NR + 8];
    logic [2:0]  pd_f3[NR + 8];
    logic [1:0]  pd_off[NR + 8];
    bit          pd_we[NR + 8];
    logic [2:0]  f3tab[8];

    initial begin
        logic [9:0] order;
        int ng, both, seen, lat, free_at, streak, f_resp, nb;
        bit idle, fok, dwin, eg_d, eg_f, e_we;
        logic [3:0] e_mask;
        logic [31:0] e_wd, e_dd, e_fd;
        logic [MEM_AW-1:0] e_addr;

        tab[0]  = '{3'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4'h0,    32'h0,        32'hDEADBEEF};
        tab[1]  = '{3'd0, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 1'b0, 4'h0,    32'h0,        32'hFFFFFF80};
        tab[2]  = '{3'd4, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 1'b0, 4'h0,    32'h0,        32'h00000080};
        tab[3]  = '{3'd1, 1'b0, 32'h102, 32'h0,        32'h80FF0000, 1'b0, 4'h0,    32'h0,        32'hFFFF80FF};
        tab[4]  = '{3'd5, 1'b0, 32'h102, 32'h0,        32'h80FF0000, 1'b0, 4'h0,    32'h0,        32'h000080FF};
        tab[5]  = '{3'd0, 1'b1, 32'h101, 32'h123,      32'h0,        1'b0, 4'b0010, 32'h23232323, 32'h0};
        tab[6]  = '{3'd1, 1'b1, 32'h101, 32'h123,      32'h0,        1'b1, 4'h0,    32'h0,        32'h0};
        tab[7]  = '{3'd2, 1'b0, 32'h102, 32'h0,        32'h11111111, 1'b1, 4'h0,    32'h0,        32'h0};
        tab[8]  = '{3'd1, 1'b1, 32'h102, 32'hABCD1234, 32'h0,        1'b0, 4'b1100, 32'h12341234, 32'h0};
        tab[9]  = '{3'd2, 1'b1, 32'h104, 32'hCAFEF00D, 32'h0,        1'b0, 4'hF,    32'hCAFEF00D, 32'h0};
        tab[10] = '{3'd3, 1'b0, 32'h108, 32'h0,        32'h12345678, 1'b0, 4'h0,    32'h0,        32'h12345678};
        tab[11] = '{3'd0, 1'b0, 32'h101, 32'h0,        32'h00007F00, 1'b0, 4'h0,    32'h0,        32'h0000007F};
        tab[12] = '{3'd5, 1'b0, 32'h103, 32'h0,        32'h22222222, 1'b1, 4'h0,    32'h0,        32'h0};
        f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        // reset held with requests pending: every output must read zero
        f_valid = 1'b1; d_valid = 1'b1;
        #2;
        check("reset_outs", {f_ready, f_rvalid, f_rdata, d_ready, d_rvalid, d_rdata, d_err,
                             mem_req, mem_we, mem_wmask, mem_addr, mem_wdata}, 128'h0);
        @(posedge clk); #1;
        reset = 1'b1; f_valid = 1'b0; d_valid = 1'b0;

        foreach (tab[i]) begin
            @(posedge clk); #1;
            d_valid = 1'b1; d_we = tab[i].we; d_func3 = tab[i].f3; d_addr = tab[i].addr;
            d_wdata = tab[i].wdata; mem_rdata = tab[i].word;
            e_addr = tab[i].err ? {MEM_AW{1'b0}} : MEM_AW'(tab[i].addr >> 2);
            @(negedge clk);
            check("tab_ready", {f_ready, d_ready}, {1'b0, 1'b1});
            check("tab_mem", {mem_req, mem_we, mem_wmask, mem_addr, mem_wdata},
                  {!tab[i].err, tab[i].we && !tab[i].err, tab[i].wmask, e_addr, tab[i].mwdata});
            @(posedge clk); #1;
            d_valid = 1'b0; d_addr = $urandom; d_func3 = 3'd7; d_we = ~d_we;
            lat = tab[i].err ? 1 : MEM_LAT + 1;
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                check("tab_early_rvalid", d_rvalid, 1'b0);
            end
            @(negedge clk);
            check("tab_resp", {d_rvalid, d_err, d_rdata}, {1'b1, tab[i].err, tab[i].rdata});
        end

        // both requesters held: fetch forced in after STREAK data grants
        @(posedge clk); #1;
        f_valid = 1'b1; f_addr = 32'h200; d_valid = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 32'h0;
        order = 10'b0; ng = 0; both = 0;
        for (int k = 0; k < 100 && ng < 10; k++) begin
            @(negedge clk);
            if (f_ready && d_ready) both++;
            if (f_ready || d_ready) begin
                order = {order[8:0], f_ready};
                ng++;
            end
            @(posedge clk); #1;
        end
        check("streak_order", order, 10'b0000100001);
        check("never_both_ready", both, 0);
        f_valid = 1'b0; d_valid = 1'b0;
        repeat (MEM_LAT + 2) @(posedge clk);
        #1;

        // flush while a fetch is outstanding
        f_valid = 1'b1; f_addr = 32'h300;
        @(negedge clk);
        check("flush_fgrant", f_ready, 1'b1);
        @(posedge clk); #1;
        f_valid = 1'b0; flush = 1'b1; d_valid = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 32'h10;
        mem_rdata = 32'h55AA55AA;
        seen = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (f_rvalid) seen++;
            if (k < 3) check("flush_dwait", d_ready, 1'b0);
            if (k == 3) check("flush_dgrant", d_ready, 1'b1);
            if (k == 6) check("flush_dresp", {d_rvalid, d_rdata}, {1'b1, 32'h55AA55AA});
            @(posedge clk); #1;
            flush = 1'b0;
            if (k == 3) d_valid = 1'b0;
        end
        check("flush_no_frvalid", seen, 0);

        // asynchronous reset in the middle of a data transaction
        d_valid = 1'b1; f_valid = 1'b1; d_func3 = 3'd2; d_addr = 32'h20;
        @(negedge clk);
        check("rst_pre_grant", d_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_async_outs", {f_ready, f_rvalid, f_rdata, d_ready, d_rvalid, d_rdata, d_err,
                                 mem_req, mem_we, mem_wmask, mem_addr, mem_wdata}, 128'h0);
        @(posedge clk); #1;
        reset = 1'b1; f_valid = 1'b0; d_valid = 1'b0;
        seen = 0;
        repeat (MEM_LAT + 2) begin
            @(negedge clk);
            if (d_rvalid || f_rvalid) seen++;
        end
        check("rst_no_stale", seen, 0);
        @(posedge clk); #1;
        d_valid = 1'b1;
        @(negedge clk);
        check("rst_idle_grant", d_ready, 1'b1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        repeat (MEM_LAT + 2) @(posedge clk);

        // randomized traffic against a timestamp model of the port
        for (int i = 0; i < NR + 8; i++) begin
            pf[i] = 1'b0; pd[i] = 1'b0; pd_f3[i] = 3'd0; pd_off[i] = 2'd0; pd_we[i] = 1'b0;
        end
        free_at = 0; streak = 0; f_resp = -1;
        for (int c = 0; c < NR; c++) begin
            @(posedge clk); #1;
            f_valid = ($urandom % 10) < 7; f_addr = $urandom; flush = ($urandom % 10) == 0;
            d_valid = ($urandom % 10) < 6; d_we = 1'($urandom % 2); d_func3 = f3tab[$urandom % 8];
            d_addr = $urandom; d_wdata = $urandom;
            nb = nbytes(d_func3);
            if (nb == 2) d_addr[0] = 1'b0;
            else if (nb == 4) d_addr[1:0] = 2'b00;
            mem_rdata = $urandom; rd_hist[c] = mem_rdata;
            @(negedge clk);
            idle = c >= free_at;
            fok  = f_valid && !flush;
            dwin = d_valid && !(fok && streak == STREAK);
            eg_d = idle && dwin;
            eg_f = idle && fok && !dwin;
            e_we = eg_d && d_we;
            e_mask = e_we ? exp_mask(d_func3, d_addr[1:0]) : 4'h0;
            e_wd   = e_we ? exp_wdata(d_func3, d_wdata) : 32'h0;
            e_addr = eg_f ? MEM_AW'(f_addr >> 2) : (eg_d ? MEM_AW'(d_addr >> 2) : {MEM_AW{1'b0}});
            e_fd   = pf[c] ? rd_hist[c-1] : 32'h0;
            e_dd   = (pd[c] && !pd_we[c]) ? exp_load(pd_f3[c], pd_off[c], rd_hist[c-1]) : 32'h0;
            check("rand_grant", {f_ready, d_ready}, {eg_f, eg_d});
            check("rand_mem", {mem_req, mem_we, mem_wmask, mem_addr, mem_wdata},
                  {eg_f || eg_d, e_we, e_mask, e_addr, e_wd});
            check("rand_fresp", {f_rvalid, f_rdata}, {pf[c], e_fd});
            check("rand_dresp", {d_rvalid, d_err, d_rdata}, {pd[c], 1'b0, e_dd});
            if (flush && f_resp > c) pf[f_resp] = 1'b0;
            if (eg_f) begin
                free_at = c + MEM_LAT + 1; f_resp = free_at; pf[free_at] = 1'b1; streak = 0;
            end
            if (eg_d) begin
                free_at = c + MEM_LAT + 1;
                pd[free_at] = 1'b1; pd_f3[free_at] = d_func3; pd_off[free_at] = d_addr[1:0];
                pd_we[free_at] = d_we;
                streak = f_valid ? ((streak < STREAK) ? streak + 1 : STREAK) : 0;
            end
        end
        f_valid = 1'b0; d_valid = 1'b0; flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
